em4100_frame_sequencer: RTL
===========================

Name: em4100_frame_sequencer

Overview:
- Sequences the 125 kHz EM4100 tag transmission.
- Builds the 64-bit EM4100 frame from a 40-bit ID: header, row parity, column parity and stop bit.
- Clocks the frame out one bit per CYCLES_PER_BIT carrier periods as a line-coded load-modulation signal.
- Sits between the ID configuration inputs and the coil modulator switch; repeats the frame continuously while enabled.

Parameters:
- CYCLES_PER_BIT, 64: carrier ticks per data bit (RF/64). Must be even and at least 2; half-bit = CYCLES_PER_BIT/2.

Ports:
- clk  input  1  system clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- carrier_tick  input  1  one-clk strobe per carrier period; all bit timing advances only on this strobe.
- enable  input  1  run request, level-sensitive.
- id_data  input  40  tag ID, {version[7:0], serial[31:0]}, transmitted MSB first.
- id_load  input  1  one-clk strobe; captures id_data into the shadow register.
- mod_out  output  1  registered modulator drive (1 = coil loaded).
- bit_out  output  1  frame bit currently being transmitted.
- bit_index  output  6  position in frame, 0..63.
- frame_start  output  1  one-clk pulse when bit 0 of a frame begins.
- busy  output  1  high while in RUN.

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values, applied on the clk edge with rst=1, including mid-frame:
  - mod_out=0, bit_out=0, bit_index=0, frame_start=0, busy=0.
  - shadow ID = 0, active frame = 0, tick counter = 0, pending flag = 0.
  - State = IDLE.
- Shadow ID:
  - id_load=1 copies id_data to the shadow and sets pending.
  - id_load is accepted in any state; the last load before a frame boundary wins.
- Frame build, when a frame starts:
  - frame[63:55] = 9'h1FF (header).
  - Rows r=0..9, MSB first: data nibble id[39-4r:36-4r], then its even-parity bit.
  - Four column-parity bits: even parity of column c (bit 3-c of every nibble) across all 10 rows, c=0 first.
  - frame[0] = 0 (stop).
  - Transmission order: frame[63] first.
- States:
  - IDLE: mod_out=0, busy=0. On carrier_tick with enable=1:
    - load the active frame from the shadow and clear pending;
    - bit_index=0, tick counter=0, pulse frame_start;
    - go to RUN.
  - RUN, on each carrier_tick:
    - Tick counter increments 0..CYCLES_PER_BIT-1.
    - At wrap, bit_index increments modulo 64.
    - At bit_index wrap 63->0 with enable=1: rebuild the frame from the shadow (a pending load takes effect exactly here), pulse frame_start, stay in RUN.
    - At bit_index wrap 63->0 with enable=0: go to IDLE.
    - Dropping enable never truncates a frame.
- Manchester coding (default):
  - First half-bit: mod_out = ~bit.
  - Second half-bit: mod_out = bit.
  - A 1 is therefore low then high.
- Latency: mod_out, bit_out, bit_index and frame_start update on the clk edge that samples carrier_tick; no other clk changes them.
- Simultaneous events:
  - rst dominates everything.
  - id_load on the same clk as a frame boundary is used for that new frame.
  - carrier_tick=0 holds all state.

Optional Feature:
- Macro: EM4100_BIPHASE_EN.
- Defined: biphase coding.
  - mod_out toggles at every bit boundary.
  - mod_out additionally toggles at mid-bit when bit=0.
  - The level entering the first bit after IDLE is 0, so the first half of bit 0 is 1.
- Undefined: Manchester as above; no biphase logic is synthesized.

Test Plan:
- Reset mid-frame at bit_index=20 -> next clk all outputs 0, state IDLE; restart begins at bit 0 with frame_start.
- Load id 40'h00_0000_0000, enable, CYCLES_PER_BIT=64 -> bits 0..63 = 64'hFF80_0000_0000_0000. Manchester: header half-bits 0,1 each 32 ticks; stop bit mod_out 1 then 0.
- Load id 40'h80_0000_0000 -> frame = nine 1s, then 1000 1, then 9 rows of 00000, then column parity 1000, then stop 0.
- Load id 40'h12_3456_789A mid-frame -> current frame unchanged; next frame uses new ID, all row and column parity bits even.
- Deassert enable at bit_index=10 -> frame completes through bit 63, then busy=0 and mod_out=0. Reassert -> frame_start on the next tick.
- With EM4100_BIPHASE_EN, id 40'h0 -> mod_out toggles every 64 ticks through the header, with extra mid-bit toggles on every 0 bit.

Source files
------------

// File: rtl/em4100_frame_sequencer.sv
// em4100_frame_sequencer
// Builds the 64-bit EM4100 frame (9-bit header, 10 rows of nibble + even
// parity, 4 column-parity bits, stop bit) from a 40-bit ID and clocks it out
// MSB first, one bit per CYCLES_PER_BIT carrier ticks, as a load-modulation
// drive. The frame repeats while enable is held high.
//
// Line coding: Manchester by default (first half-bit ~bit, second half bit).
// Define EM4100_BIPHASE_EN to select biphase coding instead (toggle at every
// bit boundary, extra mid-bit toggle for a 0; level entering bit 0 after
// IDLE is 0, so bit 0 starts high).
//
// CYCLES_PER_BIT must be even and at least 2.
module em4100_frame_sequencer #(
  parameter int CYCLES_PER_BIT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        carrier_tick,
  input  logic        enable,
  input  logic [39:0] id_data,
  input  logic        id_load,
  output logic        mod_out,
  output logic        bit_out,
  output logic [5:0]  bit_index,
  output logic        frame_start,
  output logic        busy
);

  localparam int CW   = (CYCLES_PER_BIT > 2) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int HALF = CYCLES_PER_BIT / 2;
  localparam logic [CW-1:0] TICK_LAST = CW'(CYCLES_PER_BIT - 1);
  localparam logic [CW-1:0] TICK_MID  = CW'(HALF - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        state_q;
  logic [39:0]   shadow_q;
  logic          pending_q;
  logic [63:0]   frame_q;
  logic [CW-1:0] tick_q;
  logic          mod_out_q;
  logic          bit_out_q;
  logic [5:0]    bit_index_q;
  logic          frame_start_q;
  logic          busy_q;

  logic [39:0]   id_src_d;
  logic [63:0]   built_d;
  logic [63:0]   reload_d;
  logic          next_bit_d;
  logic          mod_start_d;
  logic          mod_wrap_d;
  logic          mod_next_d;
  logic          mod_mid_d;

  // Even parity of a 4-bit nibble.
  function automatic logic even_parity4(input logic [3:0] nib);
    return ^nib;
  endfunction

  // Assemble the full 64-bit frame for one ID; bit 63 is transmitted first.
  function automatic logic [63:0] build_frame(input logic [39:0] id);
    logic [63:0] f;
    logic [3:0]  nib;
    logic [3:0]  col;
    f        = 64'd0;
    col      = 4'd0;
    f[63:55] = 9'h1FF;
    for (int r = 0; r < 10; r++) begin
      nib               = id[39 - 4*r -: 4];
      f[54 - 5*r -: 4]  = nib;
      f[50 - 5*r]       = even_parity4(nib);
      col               = col ^ nib;
    end
    // col[3] is column 0 (nibble MSB) and lands first, at f[4].
    f[4:1] = col;
    f[0]   = 1'b0;
    return f;
  endfunction

  // Frame source selection and line-coding levels for the next tick edge.
  always_comb begin
    // A load on the same clk as a frame boundary feeds that new frame.
    id_src_d   = id_load ? id_data : shadow_q;
    built_d    = build_frame(id_src_d);
    // Without a pending load the active frame already reflects the shadow.
    reload_d   = (pending_q | id_load) ? built_d : frame_q;
    next_bit_d = frame_q[6'd62 - bit_index_q];
`ifdef EM4100_BIPHASE_EN
    mod_start_d = 1'b1;
    mod_wrap_d  = ~mod_out_q;
    mod_next_d  = ~mod_out_q;
    mod_mid_d   = bit_out_q ? mod_out_q : ~mod_out_q;
`else
    mod_start_d = ~built_d[63];
    mod_wrap_d  = ~reload_d[63];
    mod_next_d  = ~next_bit_d;
    mod_mid_d   = bit_out_q;
`endif
  end

  // Sequencer FSM: shadow capture, frame timing and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      shadow_q      <= 40'd0;
      pending_q     <= 1'b0;
      frame_q       <= 64'd0;
      tick_q        <= '0;
      mod_out_q     <= 1'b0;
      bit_out_q     <= 1'b0;
      bit_index_q   <= 6'd0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      if (id_load) begin
        shadow_q  <= id_data;
        pending_q <= 1'b1;
      end
      if (carrier_tick) begin
        case (state_q)
          ST_IDLE: begin
            if (enable) begin
              frame_q       <= built_d;
              pending_q     <= 1'b0;
              tick_q        <= '0;
              bit_index_q   <= 6'd0;
              bit_out_q     <= built_d[63];
              mod_out_q     <= mod_start_d;
              frame_start_q <= 1'b1;
              busy_q        <= 1'b1;
              state_q       <= ST_RUN;
            end else begin
              mod_out_q <= 1'b0;
              busy_q    <= 1'b0;
            end
          end
          ST_RUN: begin
            if (tick_q == TICK_LAST) begin
              tick_q <= '0;
              if (bit_index_q == 6'd63) begin
                bit_index_q <= 6'd0;
                if (enable) begin
                  frame_q       <= reload_d;
                  pending_q     <= 1'b0;
                  bit_out_q     <= reload_d[63];
                  mod_out_q     <= mod_wrap_d;
                  frame_start_q <= 1'b1;
                end else begin
                  // Frame finished after enable dropped: park in IDLE.
                  bit_out_q <= 1'b0;
                  mod_out_q <= 1'b0;
                  busy_q    <= 1'b0;
                  state_q   <= ST_IDLE;
                end
              end else begin
                bit_index_q <= bit_index_q + 6'd1;
                bit_out_q   <= next_bit_d;
                mod_out_q   <= mod_next_d;
              end
            end else begin
              tick_q <= tick_q + CW'(1);
              if (tick_q == TICK_MID) begin
                mod_out_q <= mod_mid_d;
              end
            end
          end
          default: begin
            state_q   <= ST_IDLE;
            mod_out_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mod_out     = mod_out_q;
  assign bit_out     = bit_out_q;
  assign bit_index   = bit_index_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;

endmodule
